// File: rtl/rr_arbiter_n.sv
// N-requester round-robin arbiter with bounded grant hold and registered outputs.
// The owner keeps the grant for up to MAX_HOLD cycles; on release it becomes lowest priority.
module rr_arbiter_n #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 4,
   parameter int ID_W     = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    grant,
   output logic            grant_valid,
   output logic [ID_W-1:0] grant_id
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam int SUM_W = ID_W + 1;
   localparam logic [N-1:0] GNT_LSB = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   typedef struct packed {
      logic            found;
      logic [ID_W-1:0] idx;
   } pick_t;

   // First set bit of r scanning upward from p, wrapping modulo N. Scanning in
   // reverse lets the smallest offset from p overwrite any later candidate.
   function automatic pick_t rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
      pick_t            res;
      logic [SUM_W-1:0] sum;
      logic [ID_W-1:0]  idx;
      res = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum = {1'b0, p} + SUM_W'(i);
         idx = (sum >= SUM_W'(N)) ? ID_W'(sum - SUM_W'(N)) : ID_W'(sum);
         res = r[idx] ? {1'b1, idx} : res;
      end
      return res;
   endfunction

   state_t           state_r;
   logic [ID_W-1:0]  ptr_r;
   logic [ID_W-1:0]  owner_r;
   logic [CNT_W-1:0] cnt_r;
   logic [N-1:0]     grant_r;
   logic             valid_r;

   state_t           state_next_s;
   logic [ID_W-1:0]  ptr_next_s;
   logic [ID_W-1:0]  owner_next_s;
   logic [CNT_W-1:0] cnt_next_s;
   logic [N-1:0]     grant_next_s;
   logic             valid_next_s;
   logic [ID_W-1:0]  rel_ptr_s;
   pick_t            pick_idle_s;
   pick_t            pick_rel_s;

   // Next-state and next-output logic for the IDLE/BUSY arbiter.
   always_comb begin
      state_next_s = state_r;
      ptr_next_s   = ptr_r;
      owner_next_s = owner_r;
      cnt_next_s   = cnt_r;
      grant_next_s = grant_r;
      valid_next_s = valid_r;
      rel_ptr_s    = (owner_r == ID_W'(N - 1)) ? '0 : owner_r + ID_W'(1);
      pick_idle_s  = rr_pick(req, ptr_r);
      pick_rel_s   = rr_pick(req, rel_ptr_s);

      case (state_r)
         IDLE: begin
            if (pick_idle_s.found) begin
               state_next_s = BUSY;
               owner_next_s = pick_idle_s.idx;
               cnt_next_s   = CNT_W'(1);
               grant_next_s = GNT_LSB << pick_idle_s.idx;
               valid_next_s = 1'b1;
            end else begin
               state_next_s = IDLE;
               owner_next_s = '0;
               cnt_next_s   = '0;
               grant_next_s = '0;
               valid_next_s = 1'b0;
            end
         end
         BUSY: begin
            if (req[owner_r] && (cnt_r < CNT_W'(MAX_HOLD))) begin
               cnt_next_s = cnt_r + CNT_W'(1);
            end else begin
               // Release: handover in the same edge, the old owner now ranks last.
               ptr_next_s = rel_ptr_s;
               if (pick_rel_s.found) begin
                  state_next_s = BUSY;
                  owner_next_s = pick_rel_s.idx;
                  cnt_next_s   = CNT_W'(1);
                  grant_next_s = GNT_LSB << pick_rel_s.idx;
                  valid_next_s = 1'b1;
               end else begin
                  state_next_s = IDLE;
                  owner_next_s = '0;
                  cnt_next_s   = '0;
                  grant_next_s = '0;
                  valid_next_s = 1'b0;
               end
            end
         end
         default: begin
            state_next_s = IDLE;
            ptr_next_s   = '0;
            owner_next_s = '0;
            cnt_next_s   = '0;
            grant_next_s = '0;
            valid_next_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         ptr_r   <= '0;
         owner_r <= '0;
         cnt_r   <= '0;
         grant_r <= '0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         ptr_r   <= ptr_next_s;
         owner_r <= owner_next_s;
         cnt_r   <= cnt_next_s;
         grant_r <= grant_next_s;
         valid_r <= valid_next_s;
      end
   end

   assign grant       = grant_r;
   assign grant_valid = valid_r;
   assign grant_id    = owner_r;

endmodule
